spi_adc_emu: RTL and testbench
==============================

Name: spi_adc_emu

Overview:
- Synthesizable SPI responder that emulates the dual-channel 12-bit serial ADC: two MISO lines sharing one chip select and one SCK.
- Driven by the multimeter's SPI ADC reader in loopback and board bring-up, so reader and downstream scaling logic can be tested with known codes instead of analog inputs.
- Per frame it latches two parallel samples and shifts them out MSB-first behind leading zeros.

Parameters:
- DATA_W, 12, sample width per channel
- LEAD_ZEROS, 4, zero bits sent before the data MSB; FRAME_LEN = LEAD_ZEROS + DATA_W (16)

Ports:
- clk  input  1  system clock (100 MHz)
- rst_n  input  1  reset, asynchronous, active-low
- en_i  input  1  responder enable; sampled only on a CS falling edge
- sample0_i  input  DATA_W  channel 0 code to transmit
- sample1_i  input  DATA_W  channel 1 code to transmit
- spi_cs_ni  input  1  SPI chip select, active low
- spi_sck_i  input  1  SPI clock from the reader, idle low
- spi_miso_o  output  2  serial data; [0]=channel 0, [1]=channel 1
- busy_o  output  1  frame in progress
- frame_done_o  output  1  1-cycle pulse: frame ended after exactly FRAME_LEN SCK rising edges
- frame_err_o  output  1  1-cycle pulse: frame ended with any other rising-edge count

Behaviour:
- Reset: spi_miso_o=0, busy_o=0, frame_done_o=0, frame_err_o=0, state IDLE, bit counter 0, shift registers 0.
- Input conditioning:
  - cs_s/sck_s are the conditioned inputs (see Optional Feature).
  - cs_q/sck_q are their one-cycle-delayed copies.
  - Edges: cs_fall = cs_q & ~cs_s; cs_rise = ~cs_q & cs_s; sck_rise = ~sck_q & sck_s; sck_fall = sck_q & ~sck_s.
- IDLE:
  - MISO=0, busy_o=0.
  - On cs_fall with en_i=1: load shift0={LEAD_ZEROS'0, sample0_i} and shift1 likewise; clear bit counter (log2(FRAME_LEN)+1 bits); MISO = shift[FRAME_LEN-1] from the next cycle; go to SHIFT.
  - On cs_fall with en_i=0: stay IDLE for the whole frame; no done/err pulse at its end.
- SHIFT (busy_o=1):
  - sck_rise: bit counter +1. When it reaches FRAME_LEN, go to OVERRUN.
  - sck_fall: shift both registers left by one, zero-fill; MISO updates the cycle after the fall is detected.
  - Net effect: the reader samples bit FRAME_LEN-1 on the first rise and bit 0 on the FRAME_LEN-th rise.
- OVERRUN (busy_o=1):
  - MISO forced 0.
  - Further SCK edges are ignored; the counter saturates at FRAME_LEN+1 so an overrun is still detected.
- cs_rise in any non-IDLE state:
  - Go to IDLE, MISO=0.
  - Counter == FRAME_LEN -> frame_done_o pulse; otherwise -> frame_err_o pulse. Exactly one of the two, in the cycle after cs_rise is detected.
- Priorities:
  - cs_rise beats any same-cycle SCK edge.
  - cs_fall while not IDLE cannot occur; if forced, it is ignored.
- en_i deasserted mid-frame: the frame completes normally.
- Samples are latched only at frame start. Input changes mid-frame do not affect the frame in flight.
- Asynchronous reset mid-frame:
  - Immediate return to reset values.
  - The interrupted frame is abandoned, with no done/err pulse.
  - The next cs_fall starts a fresh frame.
- Timing constraint: MISO must be stable within one SCK half-period after the falling edge.
  - With sync enabled: supported SCK <= clk/8.
  - Without sync: SCK <= clk/6 (the reader's 16.66 MHz).

Optional Feature:
- Macro: SPI_ADC_EMU_SYNC_EN.
- Defined: spi_cs_ni and spi_sck_i each pass through a 2-flop synchronizer, reset to 1 and 0 respectively, before edge detection. Adds 2 cycles of edge-detect latency; required when SPI comes from pins or another domain.
- Undefined: inputs are used directly (cs_s=spi_cs_ni, sck_s=spi_sck_i). Only legal for on-chip loopback where CS/SCK are registers in the clk domain.

Test Plan:
- Loopback, no sync, SCK=clk/6, sample0=0xA5C, sample1=0x3F1, en_i=1 -> reader gets data0=0xA5C, data1=0x3F1; MISO[0] sequence 0000_1010_0101_1100; one frame_done_o pulse; frame_err_o stays 0.
- Sync enabled, SCK=clk/8, samples 0xFFF/0x000 -> MISO[0] shows 4 zeros then 12 ones, MISO[1] all zeros; frame_done_o=1 for exactly one cycle.
- CS raised after 10 SCK rises -> frame_err_o pulse; MISO=0, busy_o=0. Next full frame with 0x123/0x456 -> correct data and frame_done_o.
- 18 SCK rises before CS rises -> MISO=0 after rise 16; frame_err_o pulse; no frame_done_o.
- en_i=0 at CS fall, 16 SCK -> MISO stays 0, busy_o stays 0, no pulses. en_i dropped mid-frame (en_i=1 at CS fall) -> frame completes with frame_done_o.
- rst_n asserted after bit 7 -> all outputs 0 immediately. Change sample0 mid-frame -> next frame transmits the value latched at its own CS fall.

Source files
------------

// File: rtl/spi_adc_emu.sv
// SPI responder emulating a dual-channel 12-bit serial ADC: two MISO lanes, shared CS/SCK.
// Define SPI_ADC_EMU_SYNC_EN to pass CS/SCK through 2-flop synchronizers (pins / foreign domain).
module spi_adc_emu #(
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] sample0_i,
    input  logic [DATA_W-1:0] sample1_i,
    input  logic              spi_cs_ni,
    input  logic              spi_sck_i,
    output logic [1:0]        spi_miso_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              frame_err_o
);

    localparam int FRAME_LEN = LEAD_ZEROS + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] OVER_CNT  = CNT_W'(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

    logic cs_s, sck_s;

`ifdef SPI_ADC_EMU_SYNC_EN
    logic [1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d;

    always_comb begin
        cs_sync_d  = {cs_sync_q[0], spi_cs_ni};
        sck_sync_d = {sck_sync_q[0], spi_sck_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= 2'b11;
            sck_sync_q <= 2'b00;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
        end
    end

    assign cs_s  = cs_sync_q[1];
    assign sck_s = sck_sync_q[1];
`else
    assign cs_s  = spi_cs_ni;
    assign sck_s = spi_sck_i;
`endif

    state_t                 state_q, state_d;
    logic                   cs_q, cs_d, sck_q, sck_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   shift0_q, shift0_d, shift1_q, shift1_d;
    logic [1:0]             miso_q, miso_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_d     = cs_s;
    assign sck_d    = sck_s;
    assign cs_fall  = cs_q & ~cs_s;
    assign cs_rise  = ~cs_q & cs_s;
    assign sck_rise = ~sck_q & sck_s;
    assign sck_fall = sck_q & ~sck_s;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift0_d = shift0_q;
        shift1_d = shift1_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // CS release ends any active frame and outranks same-cycle SCK edges
        if (state_q != IDLE && cs_rise) begin
            state_d = IDLE;
            done_d  = (cnt_q == FRAME_CNT);
            err_d   = (cnt_q != FRAME_CNT);
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall && en_i) begin
                        shift0_d = {{LEAD_ZEROS{1'b0}}, sample0_i};
                        shift1_d = {{LEAD_ZEROS{1'b0}}, sample1_i};
                        cnt_d    = '0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == FRAME_CNT) begin
                            state_d = OVERRUN;
                        end
                    end else if (sck_fall) begin
                        shift0_d = {shift0_q[FRAME_LEN-2:0], 1'b0};
                        shift1_d = {shift1_q[FRAME_LEN-2:0], 1'b0};
                    end
                end
                OVERRUN: begin
                    // keep counting one past the frame so an overrun stays visible at CS release
                    if (sck_rise && cnt_q != OVER_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        miso_d = (state_d == SHIFT) ? {shift1_d[FRAME_LEN-1], shift0_d[FRAME_LEN-1]} : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            cnt_q    <= '0;
            shift0_q <= '0;
            shift1_q <= '0;
            miso_q   <= 2'b00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            cnt_q    <= cnt_d;
            shift0_q <= shift0_d;
            shift1_q <= shift1_d;
            miso_q   <= miso_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign spi_miso_o   = miso_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;

endmodule

// File: tb/tb_spi_adc_emu.sv
// Bench for spi_adc_emu: SPI reader driver, frame-level reference model, per-cycle output compare.
module tb_spi_adc_emu;

`ifdef SPI_ADC_EMU_SYNC_EN
    localparam int LAT  = 3;
    localparam int HALF = 4;
`else
    localparam int LAT  = 1;
    localparam int HALF = 3;
`endif

    logic        clk, rst_n, en_i, spi_cs_ni, spi_sck_i;
    logic [11:0] sample0_i, sample1_i;
    logic [1:0]  spi_miso_o;
    logic        busy_o, frame_done_o, frame_err_o;

    spi_adc_emu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .sample0_i    (sample0_i),
        .sample1_i    (sample1_i),
        .spi_cs_ni    (spi_cs_ni),
        .spi_sck_i    (spi_sck_i),
        .spi_miso_o   (spi_miso_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_err_o  (frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;

    // reference model: frame as words and counts of SCK edges
    bit          settled = 0;
    bit          m_active = 0;
    logic [15:0] w0, w1;
    int          rises, falls;
    logic        cs_prev = 1'b1, sck_prev = 1'b0;
    logic [1:0]  exp_miso = 2'b00;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done_o === 1'b1) n_done++;
        if (frame_err_o === 1'b1) n_err++;
        if (settled) begin
            chk("miso", 32'(spi_miso_o), 32'(exp_miso));
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("done", 32'(frame_done_o), 32'(exp_done));
            chk("err", 32'(frame_err_o), 32'(exp_err));
        end
    end

    function automatic void upd_exp();
        exp_busy = m_active;
        if (m_active && rises < 16)
            exp_miso = {1'((w1 >> (15 - falls)) & 16'h1), 1'((w0 >> (15 - falls)) & 16'h1)};
        else
            exp_miso = 2'b00;
    endfunction

    task automatic bus_edge(input logic cs, input logic sck);
        int   used;
        logic en_c;
        logic [11:0] s0_c, s1_c;
        en_c = en_i; s0_c = sample0_i; s1_c = sample1_i;
        settled   = 0;
        spi_cs_ni = cs;
        spi_sck_i = sck;
        repeat (LAT) @(posedge clk);
        #1;
        if (cs_prev && !cs) begin
            if (!m_active && en_c) begin
                m_active = 1; w0 = {4'h0, s0_c}; w1 = {4'h0, s1_c}; rises = 0; falls = 0;
            end
        end else if (!cs_prev && cs) begin
            if (m_active) begin
                exp_done = (rises == 16);
                exp_err  = (rises != 16);
            end
            m_active = 0;
        end
        if (!sck_prev && sck && m_active && rises < 17) rises++;
        if (sck_prev && !sck && m_active) falls++;
        cs_prev = cs; sck_prev = sck;
        upd_exp();
        settled = 1;
        used = LAT;
        if (exp_done || exp_err) begin
            @(posedge clk); #1;
            exp_done = 0; exp_err = 0;
            used++;
        end
        repeat (HALF - used) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        settled = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_miso", 32'(spi_miso_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(frame_done_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        spi_cs_ni = 1'b1; spi_sck_i = 1'b0; cs_prev = 1'b1; sck_prev = 1'b0;
        m_active = 0; exp_done = 0; exp_err = 0;
        upd_exp();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 settled = 1;
    endtask

    task automatic run_frame(input logic [11:0] s0, input logic [11:0] s1, input logic en,
                             input int nr, input int mut_at, input bit rst_end,
                             output logic [15:0] rx0, output logic [15:0] rx1);
        sample0_i = s0; sample1_i = s1; en_i = en;
        rx0 = '0; rx1 = '0;
        bus_edge(1'b0, 1'b0);
        for (int i = 0; i < nr; i++) begin
            if (i == mut_at) begin
                en_i = 1'b0; sample0_i = 12'($urandom); sample1_i = 12'($urandom);
            end
            rx0 = {rx0[14:0], spi_miso_o[0]};
            rx1 = {rx1[14:0], spi_miso_o[1]};
            bus_edge(1'b0, 1'b1);
            bus_edge(1'b0, 1'b0);
        end
        if (rst_end) do_reset();
        else bus_edge(1'b1, 1'b0);
        bus_edge(1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r0, r1;
        int d0, e0, nr;
        logic [11:0] s0, s1;
        logic en;

        rst_n = 1'b0; en_i = 1'b0; spi_cs_ni = 1'b1; spi_sck_i = 1'b0;
        sample0_i = '0; sample1_i = '0;
        #2;
        chk("rst_miso", 32'(spi_miso_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(frame_done_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 settled = 1;

        d0 = n_done; e0 = n_err;
        run_frame(12'hA5C, 12'h3F1, 1'b1, 16, -1, 0, r0, r1);
        chk("a5c_rx0", 32'(r0), 32'h0A5C);
        chk("a5c_rx1", 32'(r1), 32'h03F1);
        chk("a5c_done", 32'(n_done - d0), 32'd1);
        chk("a5c_err", 32'(n_err - e0), 32'd0);

        d0 = n_done; e0 = n_err;
        run_frame(12'hFFF, 12'h000, 1'b1, 16, -1, 0, r0, r1);
        chk("fff_rx0", 32'(r0), 32'h0FFF);
        chk("fff_rx1", 32'(r1), 32'h0000);
        chk("fff_done", 32'(n_done - d0), 32'd1);

        d0 = n_done; e0 = n_err;
        run_frame(12'h777, 12'h888, 1'b1, 10, -1, 0, r0, r1);
        chk("short_err", 32'(n_err - e0), 32'd1);
        chk("short_done", 32'(n_done - d0), 32'd0);
        chk("short_busy", 32'(busy_o), 32'h0);
        chk("short_miso", 32'(spi_miso_o), 32'h0);

        d0 = n_done;
        run_frame(12'h123, 12'h456, 1'b1, 16, -1, 0, r0, r1);
        chk("123_rx0", 32'(r0), 32'h0123);
        chk("456_rx1", 32'(r1), 32'h0456);
        chk("123_done", 32'(n_done - d0), 32'd1);

        d0 = n_done; e0 = n_err;
        run_frame(12'hFFF, 12'hFFF, 1'b1, 18, -1, 0, r0, r1);
        chk("over_rx0", 32'(r0), 32'h3FFC);
        chk("over_err", 32'(n_err - e0), 32'd1);
        chk("over_done", 32'(n_done - d0), 32'd0);

        d0 = n_done; e0 = n_err;
        run_frame(12'hFFF, 12'hFFF, 1'b0, 16, -1, 0, r0, r1);
        chk("dis_rx0", 32'(r0), 32'h0);
        chk("dis_rx1", 32'(r1), 32'h0);
        chk("dis_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);

        d0 = n_done;
        run_frame(12'h5A5, 12'hA5A, 1'b1, 16, 5, 0, r0, r1);
        chk("endrop_rx0", 32'(r0), 32'h05A5);
        chk("endrop_rx1", 32'(r1), 32'h0A5A);
        chk("endrop_done", 32'(n_done - d0), 32'd1);

        run_frame(12'h321, 12'h654, 1'b1, 16, -1, 0, r0, r1);
        chk("next_rx0", 32'(r0), 32'h0321);
        chk("next_rx1", 32'(r1), 32'h0654);

        d0 = n_done; e0 = n_err;
        run_frame(12'hBEE, 12'hCAB, 1'b1, 7, -1, 1, r0, r1);
        chk("rstmid_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        run_frame(12'hABC, 12'hDEF, 1'b1, 16, -1, 0, r0, r1);
        chk("post_rst_rx0", 32'(r0), 32'h0ABC);
        chk("post_rst_rx1", 32'(r1), 32'h0DEF);
        chk("post_rst_done", 32'(n_done - d0), 32'd1);

        for (int k = 0; k < 24; k++) begin
            s0 = 12'($urandom); s1 = 12'($urandom);
            en = ($urandom_range(0, 7) != 0);
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            d0 = n_done; e0 = n_err;
            run_frame(s0, s1, en, nr, (k % 5 == 0) ? 3 : -1, 0, r0, r1);
            if (en && nr == 16) begin
                chk("rnd_rx0", 32'(r0), 32'({4'h0, s0}));
                chk("rnd_rx1", 32'(r1), 32'({4'h0, s1}));
            end
            chk("rnd_done", 32'(n_done - d0), 32'((en && nr == 16) ? 1 : 0));
            chk("rnd_err", 32'(n_err - e0), 32'((en && nr != 16) ? 1 : 0));
        end

        settled = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
